// File: rtl/regfile.sv
// MIPS general-purpose register file: 2^ADDR_WIDTH registers, one write port and two read ports.
// Register 0 reads as zero. A write in the current cycle is forwarded to both read ports.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read1_enable,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    output logic [DATA_WIDTH-1:0] read1_data,
    input  logic                  read2_enable,
    input  logic [ADDR_WIDTH-1:0] read2_addr,
    output logic [DATA_WIDTH-1:0] read2_data,
    input  logic [ADDR_WIDTH-1:0] probe_addr,
    output logic [DATA_WIDTH-1:0] probe_data
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    // Register 0 has no storage; the array starts at index 1.
    logic [DATA_WIDTH-1:0] regs_q [1:NREGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NREGS-1];

    logic write_live;

    assign write_live = write_enable && (write_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (write_live) begin
            regs_d[write_addr] = write_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  rst_ok,
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  wr_live,
        input logic [ADDR_WIDTH-1:0] wr_addr,
        input logic [DATA_WIDTH-1:0] wr_data,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (rst_ok && en && (addr != '0)) begin
            if (wr_live && (wr_addr == addr)) begin
                value = wr_data;
            end else begin
                value = stored;
            end
        end
        return value;
    endfunction

    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;
    logic [DATA_WIDTH-1:0] stored_p;

    // Storage lookups are guarded so address 0 never indexes the array.
    always_comb begin
        stored1  = '0;
        stored2  = '0;
        stored_p = '0;
        if (read1_addr != '0) begin
            stored1 = regs_q[read1_addr];
        end
        if (read2_addr != '0) begin
            stored2 = regs_q[read2_addr];
        end
        if (probe_addr != '0) begin
            stored_p = regs_q[probe_addr];
        end
    end

    always_comb begin
        read1_data = read_port(reset, read1_enable, read1_addr,
                               write_live, write_addr, write_data, stored1);
        read2_data = read_port(reset, read2_enable, read2_addr,
                               write_live, write_addr, write_data, stored2);
        probe_data = reset ? stored_p : '0;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file of the MIPS core: 32 × 32-bit registers with one write port and two read ports. The write port is the far end of the execute-stage result path (`write_addr` / `write_enable` / `write_data`, delivered after the intervening pipeline registers). The two read ports serve the decode stage, which builds `operand1` / `operand2`. Register 0 is hardwired to zero, and a same-cycle write is bypassed to the readers.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width in bits.
- `ADDR_WIDTH`, 5, register index width; register count is 2^ADDR_WIDTH.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all registers.
- `write_enable` in 1: commit `write_data` to `write_addr` at the next rising edge.
- `write_addr` in ADDR_WIDTH: destination register index.
- `write_data` in DATA_WIDTH: value to store.
- `read1_enable` in 1: port 1 read request.
- `read1_addr` in ADDR_WIDTH: port 1 register index.
- `read1_data` out DATA_WIDTH: port 1 value (combinational).
- `read2_enable` in 1: port 2 read request.
- `read2_addr` in ADDR_WIDTH: port 2 register index.
- `read2_data` out DATA_WIDTH: port 2 value (combinational).
- `probe_addr` in ADDR_WIDTH: debug index, read-only.
- `probe_data` out DATA_WIDTH: stored value at `probe_addr`, no bypass (combinational).

## Operation
Storage:
- Storage is registers 1..31. Register 0 has no storage.

Write:
- On a rising edge with `reset`=1 and `write_enable`=1 and `write_addr`≠0, `regs[write_addr]` ← `write_data`.
- A write to address 0 is silently discarded.
- At most one write per cycle; there is no byte masking.

Read (each port independently; `readN_*` denotes port 1 or 2):
1. If `reset`=0, `readN_data` = 0.
2. Else if `readN_enable`=0, `readN_data` = 0.
3. Else if `readN_addr`=0, `readN_data` = 0.
4. Else if `write_enable`=1 and `write_addr`=`readN_addr`, `readN_data` = `write_data` (bypass; the value written in the same cycle is visible).
5. Else `readN_data` = `regs[readN_addr]`.

Ports and probe:
- Both read ports may address the same register; they return identical values.
- `probe_data` = `regs[probe_addr]` (0 for address 0, 0 during reset). It ignores the pending write and the enables.

Reset:
- Asserting `reset` low clears `regs[1..31]` to 0 immediately, without waiting for a clock edge.
- A write coinciding with the reset-release edge is discarded: the first write that can commit is at the first rising edge with `reset` already high.

## Timing
- Write latency: the value is visible in storage one rising edge after being presented. Through the bypass it is visible on the read ports in the same cycle (0-cycle read-after-write).
- Read latency: 0 cycles (combinational from address/enable/write-port inputs). There is no clock-to-read path other than the storage itself.
- Reset values:
  - `read1_data` = 0, `read2_data` = 0, `probe_data` = 0 while `reset`=0.
  - All storage is 0 after reset.
- Reset mid-operation: a write presented in the cycle reset asserts is lost; the register reads 0 afterwards.
- No handshake and no stall: the block always accepts a write and always answers a read.

## Test plan
- Reset then probe: hold `reset`=0 for 3 cycles with `write_enable`=1, `write_addr`=5, `write_data`=0x12345678. Release reset. Expected: `probe_data` = 0 for `probe_addr` = 0..31, and `read1_data` = 0 for all addresses.
- Basic write/read: write 0xDEADBEEF to r7 and 0x00000001 to r31 on consecutive edges. Then `read1_addr`=7, `read2_addr`=31, both enabled. Expected: `read1_data`=0xDEADBEEF, `read2_data`=0x00000001.
- Zero register: write 0xFFFFFFFF to r0. Expected: `read1_data`=0 for `read1_addr`=0 with `read1_enable`=1, both in the same cycle and afterwards; `probe_data`(0)=0.
- Bypass:
  - Setup: r3 = 0x11111111.
  - Stimulus: in one cycle present `write_enable`=1, `write_addr`=3, `write_data`=0x22222222, with `read1_addr`=3 and `read2_addr`=3 enabled.
  - Expected in that same cycle: both read ports = 0x22222222, `probe_data`(3) = 0x11111111.
  - Expected after the edge: `probe_data`(3) = 0x22222222.
- Disabled read: with r9 = 0xCAFEBABE, `read2_enable`=0 and `read2_addr`=9. Expected: `read2_data`=0; it becomes 0xCAFEBABE once `read2_enable`=1.
- Async reset mid-run: fill r1..r31 with value = index. Assert `reset` low between clock edges. Expected: all reads and `probe_data` = 0 before the next rising edge; after release, `probe_data` = 0 for every register.
